// File: rtl/uart_pkg.sv
// Shared state encoding and baud-divider helper for the UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: rd_data always presents the head word.
// Writes while full and reads while empty are ignored; pointers wrap modulo DEPTH.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter; txd is registered one clock behind the state, in_ready = !full.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd when PARITY_ODD=1) after the data.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  import uart_pkg::*;

  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD);
  localparam int          CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int          IDX_W = $clog2(DATA_W);

  if (DATA_W < 5 || DATA_W > 8 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1) || FIFO_DEPTH < 2 || FIFO_DEPTH > 256 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DIV < 1) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter combination");
  end

  tx_state_t                       state_q;
  logic                            txd_q;
  logic [CNT_W-1:0]                bit_cnt_q;
  logic [IDX_W-1:0]                bit_idx_q;
  logic [DATA_W-1:0]               shift_q;
`ifdef UART_TX_PARITY_EN
  logic                            par_q;
`endif

  logic [DATA_W-1:0]               fifo_rd_data;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]     fifo_level;
  logic                            bit_end;
  logic                            stop_end;
  logic                            pop;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign bit_end  = (bit_cnt_q == CNT_W'(DIV - 1));
  assign stop_end = (state_q == STOP) && bit_end && (bit_idx_q == IDX_W'(STOP_BITS - 1));
  // Pop from IDLE, or at the very end of STOP so back-to-back frames have no idle clock.
  assign pop      = ~fifo_empty & ((state_q == IDLE) | stop_end);

  assign in_ready = ~fifo_full;
  assign txd      = txd_q;
  assign busy     = (state_q != IDLE) | (fifo_level != '0);
  assign level    = fifo_level;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      txd_q     <= 1'b1;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        START:   txd_q <= 1'b0;
        DATA:    txd_q <= shift_q[0];
`ifdef UART_TX_PARITY_EN
        PARITY:  txd_q <= par_q;
`endif
        default: txd_q <= 1'b1;
      endcase

      if (pop) begin
        state_q   <= START;
        shift_q   <= fifo_rd_data;
        bit_cnt_q <= '0;
        bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
        par_q     <= (^fifo_rd_data) ^ (PARITY_ODD != 0);
`endif
      end else if (state_q != IDLE) begin
        if (!bit_end) begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end else begin
          bit_cnt_q <= '0;
          case (state_q)
            START: state_q <= DATA;
            DATA: begin
              shift_q <= shift_q >> 1;
              if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                state_q   <= PARITY;
`else
                state_q   <= STOP;
`endif
              end else begin
                bit_idx_q <= bit_idx_q + 1'b1;
              end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: state_q <= STOP;
`endif
            STOP: begin
              if (stop_end) begin
                bit_idx_q <= '0;
                state_q   <= IDLE;
              end else begin
                bit_idx_q <= bit_idx_q + 1'b1;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: instance A has one stop bit/even parity, B two stop bits/odd parity.
module tb_uart_tx_fifo;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = 10;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data_a, in_data_b;
  logic       in_valid_a, in_valid_b;
  logic       in_ready_a, in_ready_b;
  logic       txd_a, txd_b;
  logic       busy_a, busy_b;
  logic [2:0] level_a, level_b;

  int         checks = 0;
  int         errors = 0;
  int         sel = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_W(8), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY_ODD(0)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .txd(txd_a), .busy(busy_a), .level(level_a)
  );

  uart_tx_fifo #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_W(8), .FIFO_DEPTH(4), .STOP_BITS(2), .PARITY_ODD(1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .txd(txd_b), .busy(busy_b), .level(level_b)
  );

  function automatic logic cur_txd();
    return (sel != 0) ? txd_b : txd_a;
  endfunction
  function automatic logic cur_ready();
    return (sel != 0) ? in_ready_b : in_ready_a;
  endfunction
  function automatic logic cur_busy();
    return (sel != 0) ? busy_b : busy_a;
  endfunction
  function automatic logic [2:0] cur_level();
    return (sel != 0) ? level_b : level_a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [7:0] d);
    if (sel != 0) begin
      in_valid_b = v;
      in_data_b  = d;
    end else begin
      in_valid_a = v;
      in_data_a  = d;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic write_word(input logic [7:0] d, input int bound);
    int n = 0;
    set_in(1'b1, d);
    while (cur_ready() !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("in_ready_for_%02h", d), cur_ready(), 1'b1);
    if (cur_ready() === 1'b1) sb.push_back(d);
    @(negedge clk);
    set_in(1'b0, 8'h00);
  endtask

  task automatic wait_start(input int bound, output int waited);
    waited = 0;
    while (cur_txd() !== 1'b0 && waited < bound) begin
      @(negedge clk);
      waited++;
    end
  endtask

  // Checks every clock of one frame against the next scoreboard word.
  task automatic check_frame(input int bound, input int exp_wait, input bit chk_lvl);
    int         waited;
    int         nb;
    logic [7:0] d;
    logic [15:0] bits;
    wait_start(bound, waited);
    chk("frame_start", cur_txd(), 1'b0);
    if (cur_txd() !== 1'b0) return;
    if (exp_wait >= 0) chk("start_gap", waited, exp_wait);
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL sb_underflow observed=0 expected=nonzero");
    end
    if (sb.size() == 0) return;
    d = sb.pop_front();
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    bits[9] = (^d) ^ (sel != 0);
`endif
    nb = 1 + 8 + PAR_BITS + ((sel != 0) ? 2 : 1);
    chk("busy_in_frame", cur_busy(), 1'b1);
    if (chk_lvl) chk("level_at_start", cur_level(), sb.size());
    for (int k = 0; k < nb * DIV; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("txd_%02h_bit%0d", d, k / DIV), cur_txd(), bits[k / DIV]);
    end
  endtask

  initial begin
    int w;
    int lows;
    rst_n = 1'b0;
    in_valid_a = 1'b0; in_data_a = 8'h00;
    in_valid_b = 1'b0; in_data_b = 8'h00;
    repeat (3) @(negedge clk);

    chk("rst_txd_a", txd_a, 1'b1);
    chk("rst_level_a", level_a, 3'd0);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_ready_a", in_ready_a, 1'b1);
    chk("rst_txd_b", txd_b, 1'b1);
    chk("rst_busy_b", busy_b, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word: txd falls on the second edge after acceptance.
    sel = 0;
    write_word(8'hA5, 5);
    chk("a5_level", level_a, 3'd1);
    chk("a5_busy", busy_a, 1'b1);
    check_frame(10, 2, 1);
    chk("a5_busy_after", busy_a, 1'b0);
    chk("a5_level_after", level_a, 3'd0);
    @(negedge clk);
    chk("a5_idle_txd", txd_a, 1'b1);

    // Back-to-back writes: second write coincides with the first pop.
    write_word(8'h01, 5);
    chk("b2b_level1", level_a, 3'd1);
    write_word(8'h02, 5);
    chk("b2b_level2", level_a, 3'd1);
    write_word(8'h03, 5);
    chk("b2b_level3", level_a, 3'd2);
    check_frame(5, 0, 1);
    check_frame(5, 1, 1);
    check_frame(5, 1, 1);
    chk("b2b_busy_after", busy_a, 1'b0);

    // Six words with in_valid held: the queue fills and stalls until the next pop.
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 5; i++) write_word(8'h30 + 8'(i), 5);
        chk("full_level", level_a, 3'd4);
        chk("full_ready", in_ready_a, 1'b0);
        write_word(8'h35, 200);
      end
      begin
        check_frame(10, -1, 0);
        for (int i = 0; i < 5; i++) check_frame(5, 1, 0);
      end
    join
    chk("fill_level_after", level_a, 3'd0);
    chk("fill_sb_empty", sb.size(), 0);

    // Parity / frame length on both instances.
    write_word(8'h07, 5);
    check_frame(10, 2, 1);
    sel = 1;
    write_word(8'h07, 5);
    check_frame(10, 2, 1);

    // Two stop bits between two queued frames.
    write_word(8'h5A, 5);
    write_word(8'hC3, 5);
    chk("stop2_level", level_b, 3'd1);
    check_frame(10, 1, 1);
    check_frame(5, 1, 1);
    chk("stop2_busy_after", busy_b, 1'b0);

    // Reset during data bit 3 of 0xFF with two words queued behind it.
    sel = 0;
    @(negedge clk);
    write_word(8'hFF, 5);
    write_word(8'h11, 5);
    write_word(8'h22, 5);
    wait_start(5, w);
    chk("rst_frame_started", txd_a, 1'b0);
    repeat (45) @(negedge clk);
    chk("rst_mid_bit3", txd_a, 1'b1);
    chk("rst_mid_level", level_a, 3'd2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_txd", txd_a, 1'b1);
    chk("abort_level", level_a, 3'd0);
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_ready", in_ready_a, 1'b1);
    rst_n = 1'b1;
    sb.delete();
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (txd_a !== 1'b1) lows++;
    end
    chk("abort_no_resume", lows, 0);
    chk("abort_busy_later", busy_a, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
